// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences one complete program run on the pipelined RISC-V core:
//   1. streams a program image into instruction memory (LOAD_I),
//   2. streams an initial image into data memory (LOAD_D),
//   3. holds the core enable high for a programmed number of cycles (RUN),
//   4. streams a window of data memory, starting at address 0, back out
//      (DUMP_RD / DUMP_WAIT / DUMP_OUT),
// then parks in DONE until the next start.
//
// Ports
//   clk, arst_n            clock, asynchronous active-low reset
//   start                  begin a sequence (accepted only in IDLE or DONE)
//   imem_words/dmem_words/dump_words/run_cycles
//                          run configuration, sampled when start is accepted
//   in_valid/in_ready/in_data     load stream (valid/ready handshake)
//   out_valid/out_ready/out_data  dump stream (valid/ready handshake)
//   cpu_enable             core enable, high only in RUN
//   addr_ext/wen_ext/ren_ext/wdata_ext
//                          instruction-memory external port (write only)
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2
//                          data-memory external port
//   busy                   any state other than IDLE and DONE
//   done                   in DONE
//
// Memory strobes, the core enable and the status flags are decoded
// combinationally from the state register so that an asynchronous reset
// removes them immediately.
module cpu_run_controller #(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10,
    parameter int CYC_W       = 32
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   start,
    input  logic [IMEM_ADDR_W:0]   imem_words,
    input  logic [DMEM_ADDR_W:0]   dmem_words,
    input  logic [DMEM_ADDR_W:0]   dump_words,
    input  logic [CYC_W-1:0]       run_cycles,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_data,
    output logic                   cpu_enable,
    output logic [63:0]            addr_ext,
    output logic                   wen_ext,
    output logic                   ren_ext,
    output logic [31:0]            wdata_ext,
    output logic [63:0]            addr_ext_2,
    output logic                   wen_ext_2,
    output logic                   ren_ext_2,
    output logic [63:0]            wdata_ext_2,
    input  logic [63:0]            rdata_ext_2,
    output logic                   busy,
    output logic                   done
);

    localparam int IW = IMEM_ADDR_W + 1;
    localparam int DW = DMEM_ADDR_W + 1;
    // Shared word index must cover both memories.
    localparam int XW = (IW > DW) ? IW : DW;

    localparam logic [IW-1:0] IMEM_MAX = {1'b1, {IMEM_ADDR_W{1'b0}}};
    localparam logic [DW-1:0] DMEM_MAX = {1'b1, {DMEM_ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_I    = 3'd1,
        LOAD_D    = 3'd2,
        RUN       = 3'd3,
        DUMP_RD   = 3'd4,
        DUMP_WAIT = 3'd5,
        DUMP_OUT  = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [XW-1:0]     r_idx;
    logic [IW-1:0]     r_imem_n;
    logic [DW-1:0]     r_dmem_n;
    logic [DW-1:0]     r_dump_n;
    logic [CYC_W-1:0]  r_cyc;
    logic [63:0]       r_out_data;

    logic [IW-1:0]     w_imem_c;
    logic [DW-1:0]     w_dmem_c;
    logic [DW-1:0]     w_dump_c;
    logic [XW-1:0]     w_idx_inc;
    logic              w_start_acc;
    logic              w_idx_clr;
    logic              w_idx_step;

    // First phase with work to do; nz = {imem, dmem, run, dump} nonzero.
    function automatic state_t pick_phase(input logic [3:0] nz);
        state_t s;
        if (nz[3]) begin
            s = LOAD_I;
        end else if (nz[2]) begin
            s = LOAD_D;
        end else if (nz[1]) begin
            s = RUN;
        end else if (nz[0]) begin
            s = DUMP_RD;
        end else begin
            s = DONE;
        end
        return s;
    endfunction

    // Counts above the memory size clamp so the index can never wrap.
    assign w_imem_c  = (imem_words > IMEM_MAX) ? IMEM_MAX : imem_words;
    assign w_dmem_c  = (dmem_words > DMEM_MAX) ? DMEM_MAX : dmem_words;
    assign w_dump_c  = (dump_words > DMEM_MAX) ? DMEM_MAX : dump_words;
    assign w_idx_inc = r_idx + {{(XW-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_step  = 1'b0;
        in_ready    = 1'b0;
        wen_ext     = 1'b0;
        addr_ext    = 64'd0;
        wdata_ext   = 32'd0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = 64'd0;
        wdata_ext_2 = 64'd0;
        cpu_enable  = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_next = pick_phase({w_imem_c != '0, w_dmem_c != '0,
                                         run_cycles != '0, w_dump_c != '0});
                end else begin
                    w_next = r_state;
                end
            end
            LOAD_I: begin
                in_ready  = 1'b1;
                addr_ext  = {{(64-XW-2){1'b0}}, r_idx, 2'b00};
                wdata_ext = in_data[31:0];
                if (in_valid) begin
                    wen_ext = 1'b1;
                    if (w_idx_inc == XW'(r_imem_n)) begin
                        w_idx_clr = 1'b1;
                        w_next = pick_phase({1'b0, r_dmem_n != '0,
                                             r_cyc != '0, r_dump_n != '0});
                    end else begin
                        w_idx_step = 1'b1;
                    end
                end else begin
                    w_idx_step = 1'b0;
                end
            end
            LOAD_D: begin
                in_ready    = 1'b1;
                addr_ext_2  = {{(64-XW-3){1'b0}}, r_idx, 3'b000};
                wdata_ext_2 = in_data;
                if (in_valid) begin
                    wen_ext_2 = 1'b1;
                    if (w_idx_inc == XW'(r_dmem_n)) begin
                        w_idx_clr = 1'b1;
                        w_next = pick_phase({2'b00, r_cyc != '0, r_dump_n != '0});
                    end else begin
                        w_idx_step = 1'b1;
                    end
                end else begin
                    w_idx_step = 1'b0;
                end
            end
            RUN: begin
                cpu_enable = 1'b1;
                // Counter holds the cycles remaining including this one.
                if (r_cyc == {{(CYC_W-1){1'b0}}, 1'b1}) begin
                    w_next = pick_phase({3'b000, r_dump_n != '0});
                end else begin
                    w_next = RUN;
                end
            end
            DUMP_RD: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = {{(64-XW-3){1'b0}}, r_idx, 3'b000};
                w_next     = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                w_next = DUMP_OUT;
            end
            DUMP_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (w_idx_inc == XW'(r_dump_n)) begin
                        w_idx_clr = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_idx_step = 1'b1;
                        w_next     = DUMP_RD;
                    end
                end else begin
                    w_next = DUMP_OUT;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Configuration latch, word index, run counter and dump data register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_idx      <= '0;
            r_imem_n   <= '0;
            r_dmem_n   <= '0;
            r_dump_n   <= '0;
            r_cyc      <= '0;
            r_out_data <= 64'd0;
        end else begin
            if (w_start_acc) begin
                r_imem_n <= w_imem_c;
                r_dmem_n <= w_dmem_c;
                r_dump_n <= w_dump_c;
                r_cyc    <= run_cycles;
                r_idx    <= '0;
            end else if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_step) begin
                r_idx <= w_idx_inc;
            end
            if (r_state == RUN && r_cyc != '0) begin
                r_cyc <= r_cyc - {{(CYC_W-1){1'b0}}, 1'b1};
            end
            // Read data is valid the cycle after the read strobe.
            if (r_state == DUMP_WAIT) begin
                r_out_data <= rdata_ext_2;
            end
        end
    end

    assign out_data = r_out_data;
    assign ren_ext  = 1'b0;
    assign busy     = (r_state != IDLE) && (r_state != DONE);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  imem_words = 10'd0;
    logic [10:0] dmem_words = 11'd0;
    logic [10:0] dump_words = 11'd0;
    logic [31:0] run_cycles = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2 = 64'd0;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic [63:0] dmem [0:1023];

    cpu_run_controller dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words),
        .dump_words(dump_words), .run_cycles(run_cycles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Data memory model: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [9:0] im, input logic [10:0] dm,
                            input logic [31:0] rc, input logic [10:0] du);
        imem_words = im; dmem_words = dm; run_cycles = rc; dump_words = du;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int n;
        logic [63:0] last;
        logic [2:0] tog;

        cyc();
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cpu_en", cpu_enable, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_addr2", addr_ext_2, 64'd0);
        cyc();
        arst_n = 1'b1;
        cyc();

        // Load 3 instruction words then 2 data words, in_valid held high.
        in_valid = 1'b1;
        do_start(10'd3, 11'd2, 32'd0, 11'd0);
        for (int k = 0; k < 3; k++) begin
            in_data = 64'hFFFF_0000_1000_0000 + 64'(k);
            #1;
            check("li_wen", wen_ext, 1'b1);
            check("li_addr", addr_ext, 64'(4 * k));
            check("li_wdata", wdata_ext, 32'h1000_0000 + 32'(k));
            check("li_busy", busy, 1'b1);
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            in_data = (k == 0) ? 64'hAAAA : 64'hBBBB;
            #1;
            check("ld_wen2", wen_ext_2, 1'b1);
            check("ld_wen1", wen_ext, 1'b0);
            check("ld_addr2", addr_ext_2, 64'(8 * k));
            check("ld_wdata2", wdata_ext_2, in_data);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("l_done", done, 1'b1);
        check("l_busy", busy, 1'b0);
        check("l_in_ready", in_ready, 1'b0);
        check("l_addr2_idle", addr_ext_2, 64'd0);
        cyc();

        // in_valid toggles 1-0-1-0-1 during LOAD_I.
        do_start(10'd3, 11'd0, 32'd0, 11'd0);
        tog = 3'd0;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_data = 64'h5000 + 64'(k);
            #1;
            check("tg_wen", wen_ext, in_valid);
            check("tg_addr", addr_ext, 64'(4 * tog));
            if (in_valid) tog++;
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("tg_done", done, 1'b1);
        cyc();

        // Zero counts go straight to DONE.
        do_start(10'd0, 11'd0, 32'd0, 11'd0);
        #1;
        check("zero_done", done, 1'b1);
        cyc();

        // Run 7 cycles.
        do_start(10'd0, 11'd0, 32'd7, 11'd0);
        for (int k = 0; k < 9; k++) begin
            #1;
            check("run_en", cpu_enable, (k < 7));
            check("run_done", done, (k >= 7));
            check("run_ren2", ren_ext_2, 1'b0);
            cyc();
        end

        // Dump two words with out_ready stalled.
        do_start(10'd0, 11'd0, 32'd0, 11'd2);
        #1;
        check("d0_ren2", ren_ext_2, 1'b1);
        check("d0_addr2", addr_ext_2, 64'd0);
        check("d0_ren1", ren_ext, 1'b0);
        cyc();
        #1;
        check("d0_wait_valid", out_valid, 1'b0);
        check("d0_wait_ren2", ren_ext_2, 1'b0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("d0_valid", out_valid, 1'b1);
            check("d0_data", out_data, 64'hAAAA);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("d0_hs_valid", out_valid, 1'b1);
        cyc();
        out_ready = 1'b0;
        #1;
        check("d1_ren2", ren_ext_2, 1'b1);
        check("d1_addr2", addr_ext_2, 64'd8);
        cyc();
        cyc();
        #1;
        check("d1_valid", out_valid, 1'b1);
        check("d1_data", out_data, 64'hBBBB);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        #1;
        check("d_done", done, 1'b1);
        check("d_valid_off", out_valid, 1'b0);
        cyc();

        // Asynchronous reset in the middle of RUN.
        do_start(10'd0, 11'd0, 32'd100, 11'd0);
        cyc();
        cyc();
        #1;
        check("ar_run_en", cpu_enable, 1'b1);
        arst_n = 1'b0;
        #1;
        check("ar_cpu_en", cpu_enable, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_done", done, 1'b0);
        cyc();
        #1;
        check("ar_wen", wen_ext, 1'b0);
        check("ar_ren2", ren_ext_2, 1'b0);
        arst_n = 1'b1;
        cyc();
        in_valid = 1'b1;
        in_data = 64'h77;
        do_start(10'd1, 11'd0, 32'd0, 11'd0);
        #1;
        check("ar_restart_wen", wen_ext, 1'b1);
        check("ar_restart_addr", addr_ext, 64'd0);
        cyc();
        #1;
        check("ar_restart_done", done, 1'b1);
        cyc();

        // start during LOAD_D is ignored.
        do_start(10'd0, 11'd3, 32'd0, 11'd0);
        for (int k = 0; k < 3; k++) begin
            in_data = 64'h900 + 64'(k);
            if (k == 1) begin
                start = 1'b1;
                dmem_words = 11'd1;
                imem_words = 10'd2;
            end else begin
                start = 1'b0;
            end
            #1;
            check("sd_wen2", wen_ext_2, 1'b1);
            check("sd_addr2", addr_ext_2, 64'(8 * k));
            check("sd_wen1", wen_ext, 1'b0);
            cyc();
        end
        start = 1'b0;
        #1;
        check("sd_done", done, 1'b1);
        cyc();

        // imem_words=1023 clamps to 512 writes.
        do_start(10'd1023, 11'd0, 32'd0, 11'd0);
        n = 0;
        last = 64'd0;
        for (int c = 0; c < 700 && !done; c++) begin
            #1;
            if (wen_ext) begin
                n++;
                last = addr_ext;
            end
            cyc();
        end
        in_valid = 1'b0;
        check("clamp_count", 64'(n), 64'd512);
        check("clamp_last_addr", last, 64'd2044);
        check("clamp_done", done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences one complete program run on the pipelined RISC-V core.
- Streams a program image into instruction memory and an initial image into data memory, both through the cores' external memory ports.
- Raises the core's enable for a programmed number of cycles, then streams a window of data memory back out.
- Sits between the testbench/host interface and the core top level, and is the only driver of the external memory ports and of the core enable.

Parameters:
IMEM_ADDR_W, 9, instruction-memory word-address width; max program length 2^IMEM_ADDR_W words
DMEM_ADDR_W, 10, data-memory word-address width; max load/dump length 2^DMEM_ADDR_W words
CYC_W, 32, width of run-cycle counter

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin sequence (accepted only in IDLE or DONE)
imem_words  in  IMEM_ADDR_W+1  instruction words to load; sampled at start
dmem_words  in  DMEM_ADDR_W+1  data words to load; sampled at start
dump_words  in  DMEM_ADDR_W+1  data words to dump from address 0; sampled at start
run_cycles  in  CYC_W  cycles of cpu_enable high; sampled at start
in_valid  in  1  load stream valid
in_ready  out  1  load stream ready
in_data  in  64  load word (instruction phase uses [31:0])
out_valid  out  1  dump stream valid
out_ready  in  1  dump stream ready
out_data  out  64  dump word
cpu_enable  out  1  core enable
addr_ext  out  64  instruction-memory external byte address
wen_ext  out  1  instruction-memory external write enable
ren_ext  out  1  instruction-memory external read enable (tied 0)
wdata_ext  out  32  instruction-memory external write data
addr_ext_2  out  64  data-memory external byte address
wen_ext_2  out  1  data-memory external write enable
ren_ext_2  out  1  data-memory external read enable
wdata_ext_2  out  64  data-memory external write data
rdata_ext_2  in  64  data-memory external read data
busy  out  1  high in any state other than IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Clock and reset: single clock clk; arst_n asynchronous, active-low.
- Reset values: state IDLE; all counters 0; every output 0.
- Reset mid-operation: aborts immediately, cpu_enable drops asynchronously, and no further memory strobes are issued.
- FSM states: IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE.
- start in IDLE/DONE:
  - Latches the four config inputs; counts above 2^ADDR_W clamp to 2^ADDR_W.
  - Clears the word index and moves to the first phase with a nonzero count, in order LOAD_I, LOAD_D, RUN, DUMP_RD.
  - If all counts are 0, goes straight to DONE.
- start in any other state is ignored.
- LOAD_I:
  - in_ready=1.
  - On in_valid&in_ready in the same cycle: wen_ext=1, addr_ext=4*idx, wdata_ext=in_data[31:0], idx++.
  - After word imem_words-1 is written: idx=0, advance.
- LOAD_D: as LOAD_I, but drives wen_ext_2, addr_ext_2=8*idx and wdata_ext_2=in_data.
- in_ready is 0 outside LOAD_I and LOAD_D; wen_ext and wen_ext_2 are combinational and only high on a handshake.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles, counted by a down-counter loaded at entry.
  - Exit on the cycle the counter reaches 1; no ext strobes are issued during RUN.
- DUMP_RD: ren_ext_2=1, addr_ext_2=8*idx for one cycle, then DUMP_WAIT.
- DUMP_WAIT: rdata_ext_2 is valid the cycle after ren_ext_2; capture it into the out_data register, then DUMP_OUT.
- DUMP_OUT:
  - out_valid=1 and out_data held stable until out_ready.
  - On the handshake: idx++, then DUMP_RD, or DONE after word dump_words-1.
  - Throughput is therefore at most one word per 3 cycles.
- DONE: done=1, cpu_enable=0; stays until the next start.
- Outside its phase, every address and write-data output is held at 0.
- Index counters never wrap, because counts are clamped.

Test Plan:
- Reset then start with imem=3, dmem=2, run=0, dump=0, in_valid always 1 → wen_ext at addr 0,4,8 with in_data[31:0], then wen_ext_2 at addr 0,8; DONE 5 cycles after the first write.
- in_valid toggling 1-0-1 during LOAD_I → a write occurs only on valid cycles, and the index does not advance on idle cycles.
- run_cycles=7 with other counts 0 → cpu_enable high for exactly 7 cycles, then done=1.
- dump=2 with memory words 0xAAAA and 0xBBBB, out_ready held 0 for 4 cycles → out_valid=1 with out_data stable at 0xAAAA; after ready, second ren_ext_2 at addr 8 and out_data=0xBBBB.
- arst_n pulsed low mid-RUN → cpu_enable=0 immediately, state IDLE, busy=0; a new start works normally.
- start during LOAD_D → ignored, with the load count and config unchanged; imem_words=1023 → clamped to 512 writes.
